// File: rtl/apb_pkg.sv
// Shared APB master definitions: bus width defaults and master FSM state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_WIDTH
`define STRB_WIDTH (`DATA_WIDTH/8)
`endif

package apb_pkg;

  localparam int APB_ADDR_WIDTH = `ADDR_WIDTH;
  localparam int APB_DATA_WIDTH = `DATA_WIDTH;
  localparam int APB_STRB_WIDTH = `STRB_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin request arbiter: the first active request at or after ptr_i wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is taken.
module apb_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan requesters starting at the pointer and wrapping; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx       = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters with round-robin grant and wait-state timeout.
// Latency: grant->PSEL 1 cycle; zero-wait response 3 cycles after acceptance; 2 cycles/transfer back-to-back.
// Backpressure: req_ready pulses only in IDLE or on an ACCESS completion; PREADY=0 stalls, timeout aborts.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  // A disabled timeout still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_mst_state_e state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [ID_WIDTH-1:0]   cur_id_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic                  arb_any;
  logic                  grant_en;
  logic                  grant;

  apb_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // A grant is only taken when the bus is free or finishing; never during reset.
  assign grant     = grant_en & arb_any;
  assign req_ready = (grant_en && PRESETn) ? arb_gnt : '0;
  assign rr_ptr_d  = (arb_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_idx + ID_WIDTH'(1);

  // Next-state, grant window, wait counter and response capture.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    grant_en    = 1'b0;
    rsp_vld_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_en = 1'b1;
        if (arb_any) state_d = SETUP;
      end
      SETUP: begin
        state_d    = ACCESS;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          grant_en    = 1'b1;
          state_d     = arb_any ? SETUP : IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // Abort cycle: bus released, no new grant offered.
          if (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d   = IDLE;
            rsp_vld_d = 1'b1;
            rsp_err_d = 1'b1;
            rsp_to_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, round-robin pointer and wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (grant) rr_ptr_q <= rr_ptr_d;
    end
  end

  // Command registers: loaded on grant, held stable through the whole transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cur_id_q <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (grant) begin
      cur_id_q <= arb_idx;
      pwrite_q <= req_write[arb_idx];
      paddr_q  <= req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      pwdata_q <= req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      pstrb_q  <= req_write[arb_idx] ? req_strb[arb_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
    end
  end

  // Response registers: one-cycle valid pulse, payload updated only when a response fires.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_vld_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      if (rsp_vld_d) begin
        rsp_id_q    <= cur_id_q;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
        rsp_to_q    <= rsp_to_d;
      end
    end
  end

  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a response scoreboard.
// Latency: checks exact cycle placement of grant, SETUP, ACCESS and response.
// Backpressure: slave PREADY driven directly by the stimulus sequence.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_strb = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            rsp_timeout;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic [DW-1:0]   PRDATA = '0;
  logic            PREADY = 1'b1;
  logic            PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;
  rsp_t sb[$];

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input int id, input logic [DW-1:0] rd, input logic e, input logic t);
    rsp_t r;
    r.id    = id[1:0];
    r.rdata = rd;
    r.err   = e;
    r.to    = t;
    return r;
  endfunction

  // Scoreboard pop: every response pulse must match the oldest accepted command.
  task automatic mon();
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed id=%0d expected=no response", rsp_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
    end
  endtask

  // Sample point mid-cycle; always runs the response monitor.
  task automatic smp();
    @(negedge PCLK);
    mon();
  endtask

  task automatic adv();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_cmd(input int id, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
    req_strb[id*SW +: SW]  = s;
    req_valid[id]          = 1'b1;
  endtask

  task automatic rst_zero(input string tag);
    chk({tag, "_psel"}, 64'(PSEL), 64'd0);
    chk({tag, "_penable"}, 64'(PENABLE), 64'd0);
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'd0);
    chk({tag, "_paddr"}, 64'(PADDR), 64'd0);
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'd0);
    chk({tag, "_pstrb"}, 64'(PSTRB), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
  endtask

  initial begin
    int acc;
    int g;
    int order[5];
    logic [3:0] oh;
    order = '{0, 1, 2, 3, 0};

    // Reset state
    smp();
    rst_zero("rst");
    adv();
    PRESETn = 1'b1;

    // Single zero-wait write from requester 2
    set_cmd(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    smp();
    chk("t1_ready", 64'(req_ready), 64'b0100);
    chk("t1_psel_c0", 64'(PSEL), 64'd0);
    sb.push_back(mk(2, '0, 1'b0, 1'b0));
    adv();
    req_valid[2] = 1'b0;
    smp();
    chk("t1_setup_psel", 64'(PSEL), 64'd1);
    chk("t1_setup_pen", 64'(PENABLE), 64'd0);
    chk("t1_paddr", 64'(PADDR), 64'h10);
    chk("t1_pwrite", 64'(PWRITE), 64'd1);
    chk("t1_pwdata", 64'(PWDATA), 64'hDEADBEEF);
    chk("t1_pstrb", 64'(PSTRB), 64'hF);
    adv();
    smp();
    chk("t1_access_pen", 64'(PENABLE), 64'd1);
    chk("t1_access_psel", 64'(PSEL), 64'd1);
    adv();
    smp();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_idle_psel", 64'(PSEL), 64'd0);

    // Read from requester 1 with 3 wait states; PSLVERR ignored while PREADY=0
    adv();
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    set_cmd(1, 1'b0, 32'h20, 32'hCAFE0000, 4'hF);
    smp();
    chk("t2_ready", 64'(req_ready), 64'b0010);
    sb.push_back(mk(1, 32'h12345678, 1'b0, 1'b0));
    adv();
    req_valid[1] = 1'b0;
    smp();
    chk("t2_setup_pen", 64'(PENABLE), 64'd0);
    chk("t2_pstrb_read", 64'(PSTRB), 64'd0);
    chk("t2_pwrite", 64'(PWRITE), 64'd0);
    adv();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t2_wait_pen", 64'(PENABLE), 64'd1);
      chk("t2_wait_paddr", 64'(PADDR), 64'h20);
      chk("t2_wait_rsp", 64'(rsp_valid), 64'd0);
      adv();
    end
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h12345678;
    smp();
    chk("t2_final_pen", 64'(PENABLE), 64'd1);
    chk("t2_final_paddr", 64'(PADDR), 64'h20);
    adv();
    PRDATA = '0;
    smp();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);

    // Slave error on a write from requester 3
    adv();
    PSLVERR = 1'b1;
    set_cmd(3, 1'b1, 32'h30, 32'h55, 4'hF);
    smp();
    chk("t3_ready", 64'(req_ready), 64'b1000);
    sb.push_back(mk(3, '0, 1'b1, 1'b0));
    adv();
    req_valid[3] = 1'b0;
    smp();
    adv();
    smp();
    chk("t3_access_pen", 64'(PENABLE), 64'd1);
    adv();
    PSLVERR = 1'b0;
    smp();
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);

    // Timeout on a read from requester 0; requester 1 waits and is not granted in the abort cycle
    adv();
    PREADY = 1'b0;
    PRDATA = 32'hFFFFFFFF;
    set_cmd(0, 1'b0, 32'h40, '0, 4'hF);
    smp();
    chk("t4_ready", 64'(req_ready), 64'b0001);
    sb.push_back(mk(0, '0, 1'b1, 1'b1));
    adv();
    req_valid[0] = 1'b0;
    smp();
    chk("t4_setup_pen", 64'(PENABLE), 64'd0);
    adv();
    acc = 0;
    for (int n = 0; n < 40; n++) begin
      if (n == 3) set_cmd(1, 1'b1, 32'h44, 32'h77, 4'h3);
      smp();
      if (PSEL !== 1'b1) break;
      acc++;
      chk("t4_no_grant", 64'(req_ready), 64'd0);
      adv();
    end
    chk("t4_wait_cycles", 64'(acc), 64'(TO));
    chk("t4_abort_rsp", 64'(rsp_valid), 64'd1);
    chk("t4_abort_penable", 64'(PENABLE), 64'd0);
    chk("t4_next_ready", 64'(req_ready), 64'b0010);
    sb.push_back(mk(1, '0, 1'b0, 1'b0));
    adv();
    req_valid[1] = 1'b0;
    PREADY = 1'b1;
    PRDATA = '0;
    smp();
    chk("t4_setup_pstrb", 64'(PSTRB), 64'h3);
    adv();
    smp();
    adv();
    smp();
    chk("t4_rsp2_valid", 64'(rsp_valid), 64'd1);

    // Reset during a wait state: no response, pointer restarts at 0
    adv();
    PREADY = 1'b0;
    set_cmd(2, 1'b0, 32'h50, '0, 4'hF);
    smp();
    chk("t5_ready", 64'(req_ready), 64'b0100);
    adv();
    req_valid[2] = 1'b0;
    smp();
    adv();
    smp();
    adv();
    smp();
    chk("t5_wait_pen", 64'(PENABLE), 64'd1);
    adv();
    PRESETn = 1'b0;
    set_cmd(0, 1'b1, 32'h60, 32'hA5A5A5A5, 4'hF);
    set_cmd(3, 1'b1, 32'h70, 32'h3C, 4'h1);
    #1;
    rst_zero("mid_rst");
    smp();
    adv();
    smp();
    adv();
    PRESETn = 1'b1;
    smp();
    chk("t5_post_ready", 64'(req_ready), 64'b0001);
    sb.push_back(mk(0, '0, 1'b0, 1'b0));
    adv();
    req_valid[0] = 1'b0;
    PREADY = 1'b1;
    smp();
    chk("t5_setup_paddr", 64'(PADDR), 64'h60);
    adv();
    smp();
    chk("t5_b2b_ready", 64'(req_ready), 64'b1000);
    sb.push_back(mk(3, '0, 1'b0, 1'b0));
    adv();
    req_valid[3] = 1'b0;
    smp();
    chk("t5_b2b_rsp", 64'(rsp_valid), 64'd1);
    chk("t5_b2b_psel", 64'(PSEL), 64'd1);
    chk("t5_b2b_paddr", 64'(PADDR), 64'h70);
    adv();
    smp();
    adv();
    smp();
    chk("t5_rsp2_valid", 64'(rsp_valid), 64'd1);

    // Round-robin with all requesters continuously valid, fresh from reset
    adv();
    PRESETn = 1'b0;
    smp();
    adv();
    PRESETn = 1'b1;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, AW'(32'h100 + 4 * i), DW'(i), 4'hF);
    g = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (c > 0) chk("rr_psel", 64'(PSEL), 64'd1);
      if (c % 2 == 0) begin
        oh = 4'b0001 << order[g];
        chk("rr_grant", 64'(req_ready), 64'(oh));
        sb.push_back(mk(order[g], '0, 1'b0, 1'b0));
        g++;
      end else begin
        chk("rr_gap", 64'(req_ready), 64'd0);
      end
      adv();
      if (g == 5) req_valid = '0;
    end
    smp();
    chk("rr_last_access", 64'(PENABLE), 64'd1);
    chk("rr_last_ready", 64'(req_ready), 64'd0);
    adv();
    smp();
    chk("rr_last_rsp", 64'(rsp_valid), 64'd1);
    chk("rr_idle_psel", 64'(PSEL), 64'd0);
    adv();
    smp();
    adv();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
